// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_pkg : shared funct3, result-source and byte-enable encodings          |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Halfword accesses (funct3[1:0]==01) need off[0]==0; words need off==00.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    is_misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_branch_cond.sv
// +----------------------------------------------------------------------------+
// | branch_cond : branch condition from subtract flags, selected by funct3     |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_carry,
  input  logic       i_overflow,
  input  logic       i_zero,
  input  logic       i_negative,
  output logic       o_cond
);

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_cond = i_zero;
      F3_BNE:  o_cond = ~i_zero;
      F3_BLT:  o_cond = i_negative ^ i_overflow;
      F3_BGE:  o_cond = ~(i_negative ^ i_overflow);
      F3_BLTU: o_cond = ~i_carry;
      F3_BGEU: o_cond = i_carry;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// +----------------------------------------------------------------------------+
// | ex_mem_stage : EX->MEM pipeline boundary, branch resolve, store lanes      |
// | Optional     : define MISALIGN_TRAP_EN to squash misaligned accesses       |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              flush_i,
  input  logic              mem_ready_i,
  input  logic [XLEN-1:0]   ALUResult_i,
  input  logic              Carry_i,
  input  logic              OverFlow_i,
  input  logic              Zero_i,
  input  logic              Negative_i,
  input  logic              Branch_i,
  input  logic              Jump_i,
  input  logic [2:0]        funct3_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        ResultSrc_i,
  input  logic [XLEN-1:0]   WriteData_i,
  input  logic [XLEN-1:0]   PCTarget_i,
  input  logic [XLEN-1:0]   PCPlus4_i,
  input  logic [REG_AW-1:0] RD_i,
  output logic              PCSrc_o,
  output logic              flush_o,
  output logic [XLEN-1:0]   PCTarget_o,
  output logic              stall_o,
  output logic [XLEN-1:0]   ALUResult_M,
  output logic [XLEN-1:0]   WriteData_M,
  output logic [XLEN-1:0]   PCPlus4_M,
  output logic [REG_AW-1:0] RD_M,
  output logic [2:0]        funct3_M,
  output logic              RegWrite_M,
  output logic              MemWrite_M,
  output logic [1:0]        ResultSrc_M,
  output logic [3:0]        ByteEn_M,
  output logic              valid_M,
  output logic              misalign_o
);

  logic            w_hold;
  logic            w_cond;
  logic            w_capture_valid;
  logic            w_misalign;
  logic            w_store_ok;
  logic [1:0]      w_off;
  logic [3:0]      w_byteen;
  logic [XLEN-1:0] w_wdata;

  branch_cond u_branch_cond (
    .i_funct3   (funct3_i),
    .i_carry    (Carry_i),
    .i_overflow (OverFlow_i),
    .i_zero     (Zero_i),
    .i_negative (Negative_i),
    .o_cond     (w_cond)
  );

  // A trapped access never touches memory, so it must not wait on it.
  assign w_hold = valid_M & ~misalign_o & (MemWrite_M | (ResultSrc_M == RESULTSRC_LOAD))
                  & ~mem_ready_i;
  assign stall_o = w_hold;

  assign w_capture_valid = ex_valid_i & ~flush_i;
  assign PCSrc_o    = w_capture_valid & ~w_hold & (Jump_i | (Branch_i & w_cond));
  assign flush_o    = PCSrc_o;
  assign PCTarget_o = PCTarget_i;

  assign w_off = ALUResult_i[1:0];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_capture_valid & (MemWrite_i | (ResultSrc_i == RESULTSRC_LOAD))
                      & is_misaligned(funct3_i, w_off);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_byteen = BE_NONE;
    w_wdata  = WriteData_i;
    if (MemWrite_i) begin
      case (funct3_i)
        F3_SB: begin
          w_byteen = BE_B0 << w_off;
          w_wdata  = {4{WriteData_i[7:0]}};
        end
        F3_SH: begin
          w_byteen = BE_H0 << {w_off[1], 1'b0};
          w_wdata  = {2{WriteData_i[15:0]}};
        end
        F3_SW: begin
          w_byteen = BE_W;
          w_wdata  = WriteData_i;
        end
        default: begin
          w_byteen = BE_NONE;
          w_wdata  = WriteData_i;
        end
      endcase
    end
  end

  assign w_store_ok = w_capture_valid & MemWrite_i & ~w_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResult_M <= '0;
      WriteData_M <= '0;
      PCPlus4_M   <= '0;
      RD_M        <= '0;
      funct3_M    <= '0;
      RegWrite_M  <= 1'b0;
      MemWrite_M  <= 1'b0;
      ResultSrc_M <= '0;
      ByteEn_M    <= BE_NONE;
      valid_M     <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (!w_hold) begin
      ALUResult_M <= ALUResult_i;
      WriteData_M <= w_wdata;
      PCPlus4_M   <= PCPlus4_i;
      RD_M        <= RD_i;
      funct3_M    <= funct3_i;
      RegWrite_M  <= w_capture_valid & RegWrite_i & ~w_misalign;
      MemWrite_M  <= w_store_ok;
      ResultSrc_M <= ResultSrc_i;
      ByteEn_M    <= w_store_ok ? w_byteen : BE_NONE;
      valid_M     <= w_capture_valid;
      misalign_o  <= w_misalign;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// +----------------------------------------------------------------------------+
// | tb_ex_mem_stage : directed + randomized self-checking bench for ex_mem_stage|
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ex_mem_stage;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, flush_i, mem_ready_i;
  logic [31:0] ALUResult_i, WriteData_i, PCTarget_i, PCPlus4_i;
  logic        Carry_i, OverFlow_i, Zero_i, Negative_i;
  logic        Branch_i, Jump_i, RegWrite_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [1:0]  ResultSrc_i;
  logic [4:0]  RD_i;
  logic        PCSrc_o, flush_o, stall_o;
  logic [31:0] PCTarget_o, ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  RD_M;
  logic [2:0]  funct3_M;
  logic        RegWrite_M, MemWrite_M, valid_M, misalign_o;
  logic [1:0]  ResultSrc_M;
  logic [3:0]  ByteEn_M;

  int checks   = 0;
  int failures = 0;

  // Expected MEM-side state
  logic        e_valid, e_regwrite, e_memwrite, e_mis;
  logic [1:0]  e_resultsrc;
  logic [3:0]  e_byteen;
  logic [31:0] e_alu, e_wd, e_pc4;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .mem_ready_i(mem_ready_i), .ALUResult_i(ALUResult_i), .Carry_i(Carry_i),
    .OverFlow_i(OverFlow_i), .Zero_i(Zero_i), .Negative_i(Negative_i),
    .Branch_i(Branch_i), .Jump_i(Jump_i), .funct3_i(funct3_i),
    .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .ResultSrc_i(ResultSrc_i),
    .WriteData_i(WriteData_i), .PCTarget_i(PCTarget_i), .PCPlus4_i(PCPlus4_i),
    .RD_i(RD_i), .PCSrc_o(PCSrc_o), .flush_o(flush_o), .PCTarget_o(PCTarget_o),
    .stall_o(stall_o), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .PCPlus4_M(PCPlus4_M), .RD_M(RD_M), .funct3_M(funct3_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .ByteEn_M(ByteEn_M), .valid_M(valid_M), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_regwrite = 0; e_memwrite = 0; e_mis = 0; e_resultsrc = 0;
    e_byteen = 0; e_alu = 0; e_wd = 0; e_pc4 = 0; e_rd = 0; e_f3 = 0;
  endtask

  task automatic check_m();
    chk("valid_M", valid_M, e_valid);
    chk("RegWrite_M", RegWrite_M, e_regwrite);
    chk("MemWrite_M", MemWrite_M, e_memwrite);
    chk("ResultSrc_M", ResultSrc_M, e_resultsrc);
    chk("ByteEn_M", ByteEn_M, e_byteen);
    chk("ALUResult_M", ALUResult_M, e_alu);
    chk("WriteData_M", WriteData_M, e_wd);
    chk("PCPlus4_M", PCPlus4_M, e_pc4);
    chk("RD_M", RD_M, e_rd);
    chk("funct3_M", funct3_M, e_f3);
    chk("misalign_o", misalign_o, e_mis);
  endtask

  // Reference capture: access size in bytes, natural alignment, lane replication.
  task automatic model_capture();
    int nbytes, off, base;
    bit v, is_mem, mis, st;
    nbytes = 1 << funct3_i[1:0];
    off    = int'(ALUResult_i[1:0]);
    v      = ex_valid_i && !flush_i;
    is_mem = MemWrite_i || (ResultSrc_i == 2'b01);
    mis    = TRAP && v && is_mem && nbytes > 1 && (off % nbytes) != 0;
    st     = MemWrite_i && funct3_i <= 3'd2;
    base   = off - (off % nbytes);
    e_valid     = v;
    e_mis       = mis;
    e_regwrite  = v && RegWrite_i && !mis;
    e_memwrite  = v && MemWrite_i && !mis;
    e_byteen    = (v && st && !mis) ? 4'(((1 << nbytes) - 1) << base) : 4'd0;
    if (st && nbytes == 1)      e_wd = {24'd0, WriteData_i[7:0]} * 32'h01010101;
    else if (st && nbytes == 2) e_wd = {16'd0, WriteData_i[15:0]} * 32'h00010001;
    else                        e_wd = WriteData_i;
    e_resultsrc = ResultSrc_i;
    e_alu = ALUResult_i; e_pc4 = PCPlus4_i; e_rd = RD_i; e_f3 = funct3_i;
  endtask

  // Called at posedge+1 with EX inputs applied; returns at the next posedge+1.
  task automatic step(input bit cond_exp);
    bit h, pcs;
    #3;
    h   = e_valid && !e_mis && (e_memwrite || e_resultsrc == 2'b01) && !mem_ready_i;
    pcs = ex_valid_i && !flush_i && !h && (Jump_i || (Branch_i && cond_exp));
    chk("stall_o", stall_o, h);
    chk("PCSrc_o", PCSrc_o, pcs);
    chk("flush_o", flush_o, pcs);
    chk("PCTarget_o", PCTarget_o, PCTarget_i);
    @(posedge clk);
    if (!h) model_capture();
    #1;
    check_m();
  endtask

  task automatic idle();
    ex_valid_i = 0; flush_i = 0; mem_ready_i = 1; ALUResult_i = 0; WriteData_i = 0;
    PCTarget_i = 0; PCPlus4_i = 0; Carry_i = 0; OverFlow_i = 0; Zero_i = 0;
    Negative_i = 0; Branch_i = 0; Jump_i = 0; RegWrite_i = 0; MemWrite_i = 0;
    funct3_i = 0; ResultSrc_i = 0; RD_i = 0;
  endtask

  // Random instruction with flags derived from a real subtraction a-b.
  task automatic rand_step();
    logic [31:0] a, b, d;
    bit c;
    int kind;
    int lf [5] = '{0, 1, 2, 4, 5};
    idle();
    a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if ($urandom_range(0, 3) == 0) b = {a[31:8], 8'($urandom)};
    d = a - b;
    Zero_i = (d == 0); Negative_i = d[31]; Carry_i = (a >= b);
    OverFlow_i = (a[31] != b[31]) && (d[31] != a[31]);
    ex_valid_i  = ($urandom_range(0, 9) != 0);
    flush_i     = ($urandom_range(0, 9) == 0);
    mem_ready_i = ($urandom_range(0, 9) < 7);
    WriteData_i = $urandom; PCTarget_i = $urandom; PCPlus4_i = $urandom;
    RD_i = 5'($urandom); ALUResult_i = $urandom;
    kind = $urandom_range(0, 4);
    case (kind)
      0: begin funct3_i = 3'($urandom); RegWrite_i = 1'($urandom); end
      1: begin funct3_i = 3'(lf[$urandom_range(0, 4)]); ResultSrc_i = 2'b01; RegWrite_i = 1; end
      2: begin funct3_i = 3'($urandom_range(0, 2)); MemWrite_i = 1; end
      3: begin funct3_i = 3'($urandom); Branch_i = 1; ALUResult_i = d; end
      default: begin Jump_i = 1; RegWrite_i = 1; ResultSrc_i = 2'b10; funct3_i = 3'($urandom); end
    endcase
    case (funct3_i)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) < $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 0;
    endcase
    step(c);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_m();
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_pcsrc", PCSrc_o, 1'b0);
    rst = 0;

    // Taken BLT (N=1,V=0), then not-taken (N=1,V=1)
    idle(); ex_valid_i = 1; Branch_i = 1; funct3_i = 3'b100; Negative_i = 1;
    PCTarget_i = 32'h40;
    #3;
    chk("blt_pcsrc", PCSrc_o, 1'b1);
    chk("blt_flush", flush_o, 1'b1);
    chk("blt_target", PCTarget_o, 32'h40);
    #(-0); @(posedge clk); model_capture(); #1;
    OverFlow_i = 1;
    step(1'b0);

    // SB to 0x1003
    idle(); ex_valid_i = 1; MemWrite_i = 1; funct3_i = 3'b000;
    ALUResult_i = 32'h1003; WriteData_i = 32'hAB;
    step(1'b0);
    chk("sb_be", ByteEn_M, 4'b1000);
    chk("sb_data", WriteData_M, 32'hABABABAB);
    chk("sb_we", MemWrite_M, 1'b1);

    // LW held 3 cycles with a taken BEQ waiting in EX
    idle(); ex_valid_i = 1; ResultSrc_i = 2'b01; RegWrite_i = 1; funct3_i = 3'b010;
    ALUResult_i = 32'h2000; RD_i = 5'd5;
    step(1'b0);
    idle(); ex_valid_i = 1; Branch_i = 1; funct3_i = 3'b000; Zero_i = 1;
    PCTarget_i = 32'h80; mem_ready_i = 0;
    repeat (3) begin
      step(1'b1);
      chk("hold_stall", stall_o, 1'b1);
      chk("hold_alu", ALUResult_M, 32'h2000);
    end
    mem_ready_i = 1;
    step(1'b1);

    // Flushed EX instruction becomes a bubble
    idle(); ex_valid_i = 1; flush_i = 1; RegWrite_i = 1;
    step(1'b0);
    chk("flush_valid", valid_M, 1'b0);
    chk("flush_rw", RegWrite_M, 1'b0);

    // SW to 0x1002
    idle(); ex_valid_i = 1; MemWrite_i = 1; funct3_i = 3'b010;
    ALUResult_i = 32'h1002; WriteData_i = 32'h12345678;
    step(1'b0);
    chk("sw_mis", misalign_o, TRAP);
    chk("sw_we", MemWrite_M, !TRAP);
    chk("sw_be", ByteEn_M, TRAP ? 4'b0000 : 4'b1111);

    // Reset while a load is held
    idle(); ex_valid_i = 1; ResultSrc_i = 2'b01; RegWrite_i = 1; funct3_i = 3'b010;
    ALUResult_i = 32'h3000;
    step(1'b0);
    idle(); mem_ready_i = 0;
    step(1'b0);
    #3;
    chk("pre_rst_stall", stall_o, 1'b1);
    rst = 1;
    #1;
    model_reset();
    chk("rst_hold_stall", stall_o, 1'b0);
    check_m();
    @(posedge clk);
    #1;
    rst = 0;
    step(1'b0);

    for (int i = 0; i < 400; i++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
